twosum_finalize: RTL and testbench

TWOSUM_FINALIZE -- requirements
Module: twosum_finalize

---
 rtl/twosum_finalize.sv | 100 ++++++++++
 tb/tb_twosum_finalize.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/twosum_finalize.sv
// Finalizes a frame of compensated-sum (sum, error) pairs. Both streams are accumulated
// with modular addition. The last pair triggers a single add of sum + error, which is then held until downstream accepts it.
module twosum_finalize #(
    parameter  int EXP_WIDTH_I  = 5,
    parameter  int MANT_WIDTH_I = 2,
    parameter  int MAX_PAIRS    = 16,
    localparam int BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
    localparam int CNT_WIDTH    = $clog2(MAX_PAIRS) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [BIT_WIDTH_I-1:0] in_sum_i,
    input  logic [BIT_WIDTH_I-1:0] in_error_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [BIT_WIDTH_I-1:0] out_result_o,
    output logic [CNT_WIDTH-1:0]   out_count_o,
    output logic                   out_overflow_o
);

    typedef enum logic [1:0] {ACCUM, FINAL, HOLD} state_t;

    state_t                 state, state_next;
    logic [BIT_WIDTH_I-1:0] sum_acc, err_acc, result_r;
    logic [CNT_WIDTH-1:0]   count;
    logic                   overflow, first;
    logic                   accept, release_out;

    // Carry-out is intentionally dropped: the format wraps modulo 2^BIT_WIDTH_I.
    function automatic logic [BIT_WIDTH_I-1:0] wrap_add(input logic [BIT_WIDTH_I-1:0] a,
                                                        input logic [BIT_WIDTH_I-1:0] b);
        return a + b;
    endfunction

    assign accept      = in_valid_i & (state == ACCUM);
    assign release_out = out_ready_i & (state == HOLD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ACCUM;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i && in_last_i) state_next = FINAL;
            end
            FINAL: state_next = HOLD;
            HOLD: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_acc  <= '0;
            err_acc  <= '0;
            result_r <= '0;
            count    <= '0;
            overflow <= 1'b0;
            first    <= 1'b1;
        end else begin
            if (accept) begin
                if (first) begin
                    sum_acc <= in_sum_i;
                    err_acc <= in_error_i;
                    count   <= CNT_WIDTH'(1);
                    first   <= 1'b0;
                end else begin
                    sum_acc <= wrap_add(sum_acc, in_sum_i);
                    err_acc <= wrap_add(err_acc, in_error_i);
                    // Pairs beyond MAX_PAIRS still accumulate; only the count saturates.
                    if (count == CNT_WIDTH'(MAX_PAIRS)) overflow <= 1'b1;
                    else                               count    <= count + CNT_WIDTH'(1);
                end
            end
            if (state == FINAL) result_r <= wrap_add(sum_acc, err_acc);
            if (release_out) begin
                count    <= '0;
                overflow <= 1'b0;
                first    <= 1'b1;
            end
        end
    end

    assign out_result_o   = result_r;
    assign out_count_o    = count;
    assign out_overflow_o = overflow;

endmodule

// File: tb/tb_twosum_finalize.sv
// Bench for twosum_finalize: directed frame table, reset corner cases and random
// frames checked against a plain-arithmetic frame model.
module tb_twosum_finalize;

    localparam int EXPW = 5;
    localparam int MANTW = 2;
    localparam int MAXP = 4;
    localparam int W = 1 + EXPW + MANTW;
    localparam int CW = $clog2(MAXP) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          in_valid_i, in_ready_o, in_last_i;
    logic [W-1:0]  in_sum_i, in_error_i;
    logic          out_valid_o, out_ready_i, out_overflow_o;
    logic [W-1:0]  out_result_o;
    logic [CW-1:0] out_count_o;

    int n_tests = 0;
    int n_fail = 0;

    twosum_finalize #(.EXP_WIDTH_I(EXPW), .MANT_WIDTH_I(MANTW), .MAX_PAIRS(MAXP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_sum_i(in_sum_i), .in_error_i(in_error_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .out_count_o(out_count_o), .out_overflow_o(out_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         n;
        logic [7:0] s [5];
        logic [7:0] e [5];
        logic [7:0] res;
        int         cnt;
        bit         ovf;
        int         hold;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready_o), 1);
        check({tag, "_out_valid"}, 32'(out_valid_o), 0);
        check({tag, "_result"}, 32'(out_result_o), 0);
        check({tag, "_count"}, 32'(out_count_o), 0);
        check({tag, "_ovf"}, 32'(out_overflow_o), 0);
    endtask

    // Idle 'gap' cycles, then present one pair and return right after the edge that takes it.
    task automatic send_beat(input logic [7:0] s, input logic [7:0] e, input bit last, input int gap);
        int k;
        repeat (gap) begin
            @(negedge clk_i);
            in_valid_i = 1'b0;
            in_last_i  = 1'b0;
        end
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_sum_i   = s;
        in_error_i = e;
        in_last_i  = last;
        k = 0;
        while (!in_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (!in_ready_o) check("accept_timeout", 32'(in_ready_o), 1);
        @(posedge clk_i);
    endtask

    // Called right after the last beat's accepting edge.
    task automatic finish_frame(input logic [7:0] er, input int ec, input bit eo, input int hold);
        logic [7:0] junk;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        check("final_out_valid", 32'(out_valid_o), 0);
        check("final_in_ready", 32'(in_ready_o), 0);
        @(negedge clk_i);
        check("hold_out_valid", 32'(out_valid_o), 1);
        check("result", 32'(out_result_o), 32'(er));
        check("count", 32'(out_count_o), ec);
        check("overflow", 32'(out_overflow_o), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            // Offer pairs while the block is busy; they must not be taken.
            junk       = 8'($urandom);
            in_valid_i = 1'b1;
            in_sum_i   = junk;
            in_error_i = ~junk;
            in_last_i  = 1'($urandom);
            @(negedge clk_i);
            check("stall_out_valid", 32'(out_valid_o), 1);
            check("stall_in_ready", 32'(in_ready_o), 0);
            check("stall_result", 32'(out_result_o), 32'(er));
            check("stall_count", 32'(out_count_o), ec);
            check("stall_ovf", 32'(out_overflow_o), 32'(eo));
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        check("post_out_valid", 32'(out_valid_o), 0);
        check("post_in_ready", 32'(in_ready_o), 1);
        check("post_count", 32'(out_count_o), 0);
        check("post_ovf", 32'(out_overflow_o), 0);
    endtask

    initial begin
        vt[0] = '{1, '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h13, 1, 1'b0, 0};
        vt[1] = '{3, '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00}, '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00}, 8'h66, 3, 1'b0, 5};
        vt[2] = '{1, '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h00}, '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h10, 1, 1'b0, 1};
        vt[3] = '{5, '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01}, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h05, 4, 1'b1, 0};
        vt[4] = '{1, '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h0F, 1, 1'b0, 0};
        vt[5] = '{4, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}, 8'hF8, 4, 1'b0, 2};

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        in_sum_i    = '0;
        in_error_i  = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;

        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < vt[v].n; b++)
                send_beat(vt[v].s[b], vt[v].e[b], b == vt[v].n - 1, 0);
            finish_frame(vt[v].res, vt[v].cnt, vt[v].ovf, vt[v].hold);
        end

        // Reset mid-frame discards the partial accumulation.
        send_beat(8'h11, 8'h22, 1'b0, 0);
        send_beat(8'h33, 8'h44, 1'b0, 0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        #1 check_reset_outputs("midframe_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_beat(8'h05, 8'h00, 1'b1, 1);
        finish_frame(8'h05, 1, 1'b0, 0);

        // Reset while holding a result drops it.
        send_beat(8'h42, 8'h01, 1'b1, 0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        @(negedge clk_i);
        check("pre_rst_hold_valid", 32'(out_valid_o), 1);
        rst_ni = 1'b0;
        #1 check_reset_outputs("hold_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_beat(8'h09, 8'h01, 1'b1, 0);
        finish_frame(8'h0A, 1, 1'b0, 0);

        // Random frames against the arithmetic frame model.
        for (int f = 0; f < 40; f++) begin
            int         n;
            logic [7:0] s, e;
            int         total;
            n = int'($urandom_range(1, 7));
            total = 0;
            for (int b = 0; b < n; b++) begin
                s = 8'($urandom);
                e = 8'($urandom);
                total = total + int'(s) + int'(e);
                send_beat(s, e, b == n - 1, int'($urandom_range(0, 2)));
            end
            finish_frame(8'(total % 256), (n > MAXP) ? MAXP : n, n > MAXP, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
